// File: rtl/fib_host.sv
// fib_host: single-outstanding-job host around an iterative Fibonacci core.
// A request latches the arguments, pulses the core's r_enable for one cycle,
// then waits for the core's sticky done flag or a cycle-count timeout.
// The outcome is held on the response port until it is consumed.
module fib_host #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_n,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic [8:0]  rsp_cycles,
  output logic        core_r_enable,
  output logic [5:0]  core_init_n_t_a,
  output logic [31:0] core_init_a_t_a,
  output logic [31:0] core_init_b_t_a,
  input  logic        core_w_enable,
  input  logic [31:0] core_result,
  output logic        busy
);

  // Last counter value allowed in WAIT, and the cycle count reported on timeout.
  localparam logic [8:0] CNT_LAST = 9'(TIMEOUT - 1);
  localparam logic [8:0] CNT_FULL = 9'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  n_q, n_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        to_q, to_d;
  logic [8:0]  cyc_q, cyc_d;

  // State, argument, counter and response registers; reset abandons any job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
    end
  end

  // Next-state and handshake/core-control decode for the job sequencer.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    a_d           = a_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    res_d         = res_q;
    to_d          = to_q;
    cyc_d         = cyc_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    core_r_enable = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so no request is accepted while reset is held.
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          n_d     = req_n;
          a_d     = req_a;
          b_d     = req_b;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // The core clears its done flag here, so WAIT never sees a stale one.
        core_r_enable = 1'b1;
        cnt_d         = '0;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        // Done is tested before the limit so it wins on the final cycle.
        if (core_w_enable) begin
          res_d   = core_result;
          to_d    = 1'b0;
          cyc_d   = cnt_q;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          to_d    = 1'b1;
          cyc_d   = CNT_FULL;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy            = (state_q != S_IDLE);
  assign rsp_result      = res_q;
  assign rsp_timeout     = to_q;
  assign rsp_cycles      = cyc_q;
  assign core_init_n_t_a = n_q;
  assign core_init_a_t_a = a_q;
  assign core_init_b_t_a = b_q;

endmodule
